// File: rtl/bbox_sched.sv
// Bounding-box scheduler: sequences one fp_min and one fp_max unit through four compare passes per triangle.
// Latency: 1 + 4*(L+1) cycles from the accept cycle to bbox_valid, where L is the slower unit's latency.
// Backpressure: stalls in ISSUE until both units are ready, holds the result in OUT until bbox_ready; tri_ready only in IDLE.
module bbox_sched #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tri_valid,
    output logic         tri_ready,
    input  logic [W-1:0] x0,
    input  logic [W-1:0] y0,
    input  logic [W-1:0] x1,
    input  logic [W-1:0] y1,
    input  logic [W-1:0] x2,
    input  logic [W-1:0] y2,
    output logic         bbox_valid,
    input  logic         bbox_ready,
    output logic [W-1:0] xmin,
    output logic [W-1:0] xmax,
    output logic [W-1:0] ymin,
    output logic [W-1:0] ymax,
    output logic         min_nd,
    output logic         max_nd,
    input  logic         min_us_rfd,
    input  logic         max_us_rfd,
    output logic [W-1:0] min_a,
    output logic [W-1:0] min_b,
    output logic [W-1:0] max_a,
    output logic [W-1:0] max_b,
    output logic         min_ds_rfd,
    output logic         max_ds_rfd,
    input  logic         min_rdy,
    input  logic         max_rdy,
    input  logic [W-1:0] min_res,
    input  logic [W-1:0] max_res
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [1:0]   pass;
    logic         dmin, dmax;
    logic [W-1:0] rmin, rmax;
    logic [W-1:0] lx0, ly0, lx1, ly1, lx2, ly2;

    logic         accept;
    logic         issue;
    logic         cap_min, cap_max;
    logic         pass_done;
    logic [W-1:0] min_new, max_new;

    // A result captured in the same cycle the pass completes must be used directly.
    assign min_new = cap_min ? min_res : rmin;
    assign max_new = cap_max ? max_res : rmax;

    // Next-state, handshake strobes and operand selection for the current pass.
    always_comb begin
        state_nxt  = state;
        tri_ready  = 1'b0;
        bbox_valid = 1'b0;
        min_nd     = 1'b0;
        max_nd     = 1'b0;
        min_ds_rfd = 1'b0;
        max_ds_rfd = 1'b0;
        min_a      = '0;
        min_b      = '0;
        max_a      = '0;
        max_b      = '0;
        accept     = 1'b0;
        issue      = 1'b0;
        cap_min    = 1'b0;
        cap_max    = 1'b0;
        pass_done  = 1'b0;
        case (state)
            S_IDLE: begin
                // Not ready while reset is held, even though the state is already IDLE.
                tri_ready = rst;
                if (tri_valid) begin
                    accept    = 1'b1;
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                case (pass)
                    2'd0: begin
                        min_a = lx0;  max_a = lx0;
                        min_b = lx1;  max_b = lx1;
                    end
                    2'd1: begin
                        min_a = rmin; max_a = rmax;
                        min_b = lx2;  max_b = lx2;
                    end
                    2'd2: begin
                        min_a = ly0;  max_a = ly0;
                        min_b = ly1;  max_b = ly1;
                    end
                    default: begin
                        min_a = rmin; max_a = rmax;
                        min_b = ly2;  max_b = ly2;
                    end
                endcase
                // Both units issue together or not at all.
                if (min_us_rfd && max_us_rfd) begin
                    min_nd    = 1'b1;
                    max_nd    = 1'b1;
                    issue     = 1'b1;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                min_ds_rfd = ~dmin;
                max_ds_rfd = ~dmax;
                cap_min    = min_rdy & ~dmin;
                cap_max    = max_rdy & ~dmax;
                if ((dmin | cap_min) && (dmax | cap_max)) begin
                    pass_done = 1'b1;
                    state_nxt = (pass == 2'd3) ? S_OUT : S_ISSUE;
                end
            end
            default: begin
                bbox_valid = 1'b1;
                if (bbox_ready) begin
                    state_nxt = S_IDLE;
                end
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Vertex latch, pass counter, unit result capture and box publication.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pass <= 2'd0;
            dmin <= 1'b0;
            dmax <= 1'b0;
            rmin <= '0;
            rmax <= '0;
            lx0  <= '0;
            ly0  <= '0;
            lx1  <= '0;
            ly1  <= '0;
            lx2  <= '0;
            ly2  <= '0;
            xmin <= '0;
            xmax <= '0;
            ymin <= '0;
            ymax <= '0;
        end else begin
            if (accept) begin
                lx0  <= x0;
                ly0  <= y0;
                lx1  <= x1;
                ly1  <= y1;
                lx2  <= x2;
                ly2  <= y2;
                pass <= 2'd0;
            end
            if (issue) begin
                dmin <= 1'b0;
                dmax <= 1'b0;
            end
            if (cap_min) begin
                rmin <= min_res;
                dmin <= 1'b1;
            end
            if (cap_max) begin
                rmax <= max_res;
                dmax <= 1'b1;
            end
            if (pass_done) begin
                if (pass == 2'd1) begin
                    xmin <= min_new;
                    xmax <= max_new;
                end
                if (pass == 2'd3) begin
                    ymin <= min_new;
                    ymax <= max_new;
                end else begin
                    pass <= pass + 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bbox_sched.sv
module tb_bbox_sched;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         tri_valid, tri_ready;
    logic [W-1:0] x0, y0, x1, y1, x2, y2;
    logic         bbox_valid, bbox_ready;
    logic [W-1:0] xmin, xmax, ymin, ymax;
    logic         min_nd, max_nd, min_us_rfd, max_us_rfd;
    logic [W-1:0] min_a, min_b, max_a, max_b;
    logic         min_ds_rfd, max_ds_rfd, min_rdy, max_rdy;
    logic [W-1:0] min_res, max_res;

    bbox_sched #(.W(W)) dut (
        .clk(clk), .rst(rst),
        .tri_valid(tri_valid), .tri_ready(tri_ready),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1), .x2(x2), .y2(y2),
        .bbox_valid(bbox_valid), .bbox_ready(bbox_ready),
        .xmin(xmin), .xmax(xmax), .ymin(ymin), .ymax(ymax),
        .min_nd(min_nd), .max_nd(max_nd),
        .min_us_rfd(min_us_rfd), .max_us_rfd(max_us_rfd),
        .min_a(min_a), .min_b(min_b), .max_a(max_a), .max_b(max_b),
        .min_ds_rfd(min_ds_rfd), .max_ds_rfd(max_ds_rfd),
        .min_rdy(min_rdy), .max_rdy(max_rdy),
        .min_res(min_res), .max_res(max_res)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // staged stimulus, applied at the next falling edge
    logic        tv_s = 1'b0, br_s = 1'b1;
    logic [15:0] tx[3], ty[3];
    logic        min_stall = 1'b0, max_stall = 1'b0;
    int          lat_min = 1, lat_max = 1;

    // external unit models
    logic        mu_have = 1'b0, xu_have = 1'b0;
    int          mu_cnt = 0, xu_cnt = 0;
    logic [15:0] mu_val = '0, xu_val = '0;

    // transaction-level expectation
    logic        in_flight = 1'b0;
    logic [15:0] ex[3], ey[3];
    int          ndm = 0, ndx = 0, capm = 0, capx = 0;
    logic        owed_m = 1'b0, owed_x = 1'b0;
    int          acc_cyc = 0, hs_cyc = 0, done_cnt = 0, last_lat = 0;
    logic        bv_seen = 1'b0;
    logic        s_nd = 1'b0;
    logic [63:0] box_r = '0;

    // fp16 total order for non-NaN values
    function automatic logic [15:0] okey(input logic [15:0] v);
        return v[15] ? ~v : (v | 16'h8000);
    endfunction
    function automatic logic [15:0] fmin(input logic [15:0] a, input logic [15:0] b);
        return (okey(a) <= okey(b)) ? a : b;
    endfunction
    function automatic logic [15:0] fmax(input logic [15:0] a, input logic [15:0] b);
        return (okey(a) >= okey(b)) ? a : b;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_tri_ready", tri_ready, 0);
        chk("rst_bbox_valid", bbox_valid, 0);
        chk("rst_nd", {min_nd, max_nd}, 0);
        chk("rst_ds_rfd", {min_ds_rfd, max_ds_rfd}, 0);
        chk("rst_box", {xmin, xmax, ymin, ymax}, 0);
        chk("rst_operands", {min_a, min_b, max_a, max_b}, 0);
    endtask

    // per-cycle comparison of DUT outputs against the transaction model
    task automatic compare();
        logic [15:0] ema, exa, eb0, eb1;
        chk("tri_ready", tri_ready, rst && !in_flight);
        chk("bbox_valid", bbox_valid, in_flight && capm == 4 && capx == 4);
        chk("min_ds_rfd", min_ds_rfd, owed_m);
        chk("max_ds_rfd", max_ds_rfd, owed_x);
        chk("nd_pair", min_nd, max_nd);
        s_nd = min_nd | max_nd;
        if (min_nd || max_nd) begin
            chk("nd_gate", min_us_rfd && max_us_rfd && in_flight && ndm < 4, 1);
            case (ndm)
                0: begin ema = ex[0]; exa = ex[0]; eb0 = ex[1]; end
                1: begin ema = fmin(ex[0], ex[1]); exa = fmax(ex[0], ex[1]); eb0 = ex[2]; end
                2: begin ema = ey[0]; exa = ey[0]; eb0 = ey[1]; end
                default: begin ema = fmin(ey[0], ey[1]); exa = fmax(ey[0], ey[1]); eb0 = ey[2]; end
            endcase
            eb1 = eb0;
            chk("operands", {min_a, min_b, max_a, max_b}, {ema, eb0, exa, eb1});
        end
        if (bbox_valid) begin
            chk("xmin", xmin, fmin(fmin(ex[0], ex[1]), ex[2]));
            chk("xmax", xmax, fmax(fmax(ex[0], ex[1]), ex[2]));
            chk("ymin", ymin, fmin(fmin(ey[0], ey[1]), ey[2]));
            chk("ymax", ymax, fmax(fmax(ey[0], ey[1]), ey[2]));
            if (!bv_seen) begin
                bv_seen  = 1'b1;
                last_lat = cyc - acc_cyc;
            end
        end
    endtask

    // advance the model by the handshakes that happen on the coming rising edge
    task automatic update();
        if (tri_valid && tri_ready) begin
            in_flight = 1'b1;
            ex = tx; ey = ty;
            ndm = 0; ndx = 0; capm = 0; capx = 0;
            acc_cyc = cyc;
            bv_seen = 1'b0;
        end
        if (bbox_valid && bbox_ready) begin
            chk("nd_count_min", ndm, 4);
            chk("nd_count_max", ndx, 4);
            box_r = {xmin, xmax, ymin, ymax};
            in_flight = 1'b0;
            hs_cyc = cyc;
            done_cnt++;
        end
        if (min_rdy && min_ds_rfd) begin mu_have = 1'b0; capm++; owed_m = 1'b0; end
        if (min_nd) begin
            mu_have = 1'b1; mu_cnt = lat_min - 1; mu_val = fmin(min_a, min_b);
            ndm++; owed_m = 1'b1;
        end else if (mu_have && mu_cnt > 0) mu_cnt--;
        if (max_rdy && max_ds_rfd) begin xu_have = 1'b0; capx++; owed_x = 1'b0; end
        if (max_nd) begin
            xu_have = 1'b1; xu_cnt = lat_max - 1; xu_val = fmax(max_a, max_b);
            ndx++; owed_x = 1'b1;
        end else if (xu_have && xu_cnt > 0) xu_cnt--;
    endtask

    task automatic step();
        @(negedge clk);
        min_rdy    = mu_have && mu_cnt == 0;
        min_res    = mu_have ? mu_val : 16'h0;
        min_us_rfd = !mu_have && !min_stall;
        max_rdy    = xu_have && xu_cnt == 0;
        max_res    = xu_have ? xu_val : 16'h0;
        max_us_rfd = !xu_have && !max_stall;
        tri_valid  = tv_s;
        bbox_ready = br_s;
        x0 = tx[0]; x1 = tx[1]; x2 = tx[2];
        y0 = ty[0]; y1 = ty[1]; y2 = ty[2];
        #1;
        compare();
        update();
        cyc++;
    endtask

    task automatic run_until_done(input int budget);
        int start = done_cnt;
        int n = 0;
        while (done_cnt == start && n < budget) begin
            step();
            n++;
        end
        chk("done_in_budget", done_cnt != start, 1);
    endtask

    task automatic set_tri(input logic [15:0] a0, input logic [15:0] a1, input logic [15:0] a2,
                           input logic [15:0] b0, input logic [15:0] b1, input logic [15:0] b2);
        tx[0] = a0; tx[1] = a1; tx[2] = a2;
        ty[0] = b0; ty[1] = b1; ty[2] = b2;
    endtask

    initial begin
        int n;
        rst = 1'b0;
        tri_valid = 1'b0; bbox_ready = 1'b0;
        min_us_rfd = 1'b0; max_us_rfd = 1'b0; min_rdy = 1'b0; max_rdy = 1'b0;
        min_res = '0; max_res = '0;
        x0 = '0; x1 = '0; x2 = '0; y0 = '0; y1 = '0; y2 = '0;
        set_tri(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        ex = tx; ey = ty;
        #2;
        chk_reset_vals();
        step(); step();
        rst = 1'b1;
        step();

        // basic: L=1 on both units
        set_tri(16'h0000, 16'h3800, 16'h3C00, 16'h4000, 16'hBC00, 16'h4200);
        tv_s = 1'b1; step(); tv_s = 1'b0;
        run_until_done(60);
        chk("basic_box", box_r, {16'h0000, 16'h3C00, 16'hBC00, 16'h4200});
        chk("basic_latency", last_lat, 9);

        // fp_max not ready for the first 5 ISSUE cycles
        set_tri(16'hC000, 16'h4400, 16'h3000, 16'h3555, 16'hB555, 16'h1234);
        max_stall = 1'b1;
        tv_s = 1'b1; step(); tv_s = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_no_nd", s_nd, 0);
        end
        max_stall = 1'b0;
        step();
        chk("bp_issue", s_nd, 1);
        run_until_done(60);
        chk("bp_box", box_r, {16'hC000, 16'h4400, 16'hB555, 16'h3555});
        chk("bp_latency", last_lat, 14);

        // skewed latency: fp_min 1, fp_max 4
        lat_max = 4;
        set_tri(16'h4800, 16'hC400, 16'h4600, 16'h8400, 16'h0400, 16'h8200);
        tv_s = 1'b1; step(); tv_s = 1'b0;
        run_until_done(100);
        chk("skew_box", box_r, {16'hC400, 16'h4800, 16'h8400, 16'h0400});
        chk("skew_latency", last_lat, 21);
        lat_max = 1;

        // output stall with a second triangle held on the input
        set_tri(16'h0000, 16'h3800, 16'h3C00, 16'h4000, 16'hBC00, 16'h4200);
        br_s = 1'b0;
        tv_s = 1'b1; step();
        set_tri(16'hC000, 16'h4400, 16'h3000, 16'h3555, 16'hB555, 16'h1234);
        n = 0;
        while (!bv_seen && n < 60) begin step(); n++; end
        chk("stall_bv_seen", bv_seen, 1);
        for (int i = 0; i < 10; i++) step();
        br_s = 1'b1;
        step();
        chk("stall_box", box_r, {16'h0000, 16'h3C00, 16'hBC00, 16'h4200});
        step();
        chk("reaccept_cycle", acc_cyc, hs_cyc + 1);
        tv_s = 1'b0;
        run_until_done(60);
        chk("second_box", box_r, {16'hC000, 16'h4400, 16'hB555, 16'h3555});

        // reset during WAIT of pass 2
        set_tri(16'h0000, 16'h3800, 16'h3C00, 16'h4000, 16'hBC00, 16'h4200);
        tv_s = 1'b1; step(); tv_s = 1'b0;
        n = 0;
        while (ndm < 3 && n < 60) begin step(); n++; end
        chk("reached_pass2", ndm, 3);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk_reset_vals();
        in_flight = 1'b0; ndm = 0; ndx = 0; capm = 0; capx = 0;
        owed_m = 1'b0; owed_x = 1'b0;
        step(); step();
        rst = 1'b1;
        step(); step();
        mu_have = 1'b0; xu_have = 1'b0;
        set_tri(16'h4800, 16'hC400, 16'h4600, 16'h8400, 16'h0400, 16'h8200);
        tv_s = 1'b1; step(); tv_s = 1'b0;
        run_until_done(60);
        chk("post_reset_box", box_r, {16'hC400, 16'h4800, 16'h8400, 16'h0400});
        chk("post_reset_latency", last_lat, 9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
